// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multi-port register file.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int RF_DATA_W   = 19;
    localparam int RF_NUM_REGS = 8;
    localparam int RF_AW       = $clog2(RF_NUM_REGS);

    typedef logic [RF_AW-1:0]     rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

    // A write or reserve only takes effect when enabled and, with a hardwired
    // zero register, when it does not target register 0.
    function automatic logic rf_eff_wr(input logic en, input logic [31:0] addr,
                                       input logic zero_reg);
        return en && !(zero_reg && (addr == 32'd0));
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of read, write, reserve and status signals of the register file.
// Latency: n/a (wiring only).
// Backpressure: none; all ports are fire-and-forget.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD-1:0][AW-1:0]     rd_addr_i;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data_o;
    logic [NUM_RD-1:0]             rd_busy_o;
    logic                          wr0_en_i;
    logic [AW-1:0]                 wr0_addr_i;
    logic [DATA_W-1:0]             wr0_data_i;
    logic                          wr1_en_i;
    logic [AW-1:0]                 wr1_addr_i;
    logic [DATA_W-1:0]             wr1_data_i;
    logic                          rsv_en_i;
    logic [AW-1:0]                 rsv_addr_i;
    logic                          wr_collision_o;

    modport master (
        output rd_addr_i, wr0_en_i, wr0_addr_i, wr0_data_i,
               wr1_en_i, wr1_addr_i, wr1_data_i, rsv_en_i, rsv_addr_i,
        input  rd_data_o, rd_busy_o, wr_collision_o
    );

    modport slave (
        input  rd_addr_i, wr0_en_i, wr0_addr_i, wr0_data_i,
               wr1_en_i, wr1_addr_i, wr1_data_i, rsv_en_i, rsv_addr_i,
        output rd_data_o, rd_busy_o, wr_collision_o
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by issue-stage reserves, cleared by writebacks.
// Latency: 1 cycle reserve/clear to registered state; busy reads combinational.
// Backpressure: none; callers stall on rd_busy_o themselves.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr0_en_i,
    input  logic [AW-1:0]             wr0_addr_i,
    input  logic                      wr1_en_i,
    input  logic [AW-1:0]             wr1_addr_i,
    input  logic                      rsv_en_i,
    input  logic [AW-1:0]             rsv_addr_i,
    input  logic [NUM_RD-1:0][AW-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]         rd_busy_o
);
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                eff0;
    logic                eff1;
    logic                effr;

    assign eff0 = rf_eff_wr(wr0_en_i, 32'(wr0_addr_i), ZERO_REG != 0);
    assign eff1 = rf_eff_wr(wr1_en_i, 32'(wr1_addr_i), ZERO_REG != 0);
    assign effr = rf_eff_wr(rsv_en_i, 32'(rsv_addr_i), ZERO_REG != 0);

    // Writebacks clear first, then a reserve sets: a newer producer wins.
    always_comb begin
        busy_d = busy_q;
        if (eff0) busy_d[wr0_addr_i] = 1'b0;
        if (eff1) busy_d[wr1_addr_i] = 1'b0;
        if (effr) busy_d[rsv_addr_i] = 1'b1;
    end

    // Busy bit register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    // Per-port busy view; a same-cycle writeback releases the register early.
    always_comb begin
        rd_busy_o = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (ZERO_REG != 0 && rd_addr_i[p] == '0) begin
                rd_busy_o[p] = 1'b0;
            end else if (BYPASS != 0 &&
                         ((eff0 && rd_addr_i[p] == wr0_addr_i) ||
                          (eff1 && rd_addr_i[p] == wr1_addr_i))) begin
                rd_busy_o[p] = effr && (rd_addr_i[p] == rsv_addr_i);
            end else begin
                rd_busy_o[p] = busy_q[rd_addr_i[p]];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports and busy scoreboard.
// Latency: writes visible after 1 cycle (same cycle with BYPASS); reads combinational.
// Backpressure: none; wr1 is silently dropped when it collides with wr0.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] mem_d;
    logic [NUM_RD-1:0][DATA_W-1:0]   rd_data;
    logic                            collision_q;
    logic                            collision_d;
    logic                            eff0;
    logic                            eff1;

    assign eff0 = rf_eff_wr(bus.wr0_en_i, 32'(bus.wr0_addr_i), ZERO_REG != 0);
    assign eff1 = rf_eff_wr(bus.wr1_en_i, 32'(bus.wr1_addr_i), ZERO_REG != 0);

    // Write arbitration: wr0 is applied last so it overrides wr1 on a tie.
    always_comb begin
        mem_d       = mem_q;
        collision_d = eff0 && eff1 && (bus.wr0_addr_i == bus.wr1_addr_i);
        if (eff1) mem_d[bus.wr1_addr_i] = bus.wr1_data_i;
        if (eff0) mem_d[bus.wr0_addr_i] = bus.wr0_data_i;
    end

    // Storage array and collision pulse flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q       <= '0;
            collision_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            collision_q <= collision_d;
        end
    end

    // Read muxes with optional same-cycle forwarding of write data.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (ZERO_REG != 0 && bus.rd_addr_i[p] == '0) begin
                rd_data[p] = '0;
            end else if (BYPASS != 0 && eff0 && bus.rd_addr_i[p] == bus.wr0_addr_i) begin
                rd_data[p] = bus.wr0_data_i;
            end else if (BYPASS != 0 && eff1 && bus.rd_addr_i[p] == bus.wr1_addr_i) begin
                rd_data[p] = bus.wr1_data_i;
            end else begin
                rd_data[p] = mem_q[bus.rd_addr_i[p]];
            end
        end
    end

    assign bus.rd_data_o      = rd_data;
    assign bus.wr_collision_o = collision_q;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .wr0_en_i   (bus.wr0_en_i),
        .wr0_addr_i (bus.wr0_addr_i),
        .wr1_en_i   (bus.wr1_en_i),
        .wr1_addr_i (bus.wr1_addr_i),
        .rsv_en_i   (bus.rsv_en_i),
        .rsv_addr_i (bus.rsv_addr_i),
        .rd_addr_i  (bus.rd_addr_i),
        .rd_busy_o  (bus.rd_busy_o)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypass, no-bypass and wide/4-port configurations.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_mp;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    regfile_mp_if #(.DATA_W(19), .NUM_REGS(8),  .NUM_RD(2)) if_byp ();
    regfile_mp_if #(.DATA_W(19), .NUM_REGS(8),  .NUM_RD(2)) if_nb ();
    regfile_mp_if #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(4)) if_w ();

    regfile_mp #(.DATA_W(19), .NUM_REGS(8), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1))
        u_byp (.clk(clk), .reset(reset), .bus(if_byp));
    regfile_mp #(.DATA_W(19), .NUM_REGS(8), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1))
        u_nb (.clk(clk), .reset(reset), .bus(if_nb));
    regfile_mp #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1))
        u_w (.clk(clk), .reset(reset), .bus(if_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        if_byp.wr0_en_i = 0; if_byp.wr1_en_i = 0; if_byp.rsv_en_i = 0;
        if_nb.wr0_en_i  = 0; if_nb.wr1_en_i  = 0; if_nb.rsv_en_i  = 0;
        if_w.wr0_en_i   = 0; if_w.wr1_en_i   = 0; if_w.rsv_en_i   = 0;
    endtask

    task automatic set_wr0(input logic [2:0] a, input logic [18:0] d);
        if_byp.wr0_en_i = 1; if_byp.wr0_addr_i = a; if_byp.wr0_data_i = d;
        if_nb.wr0_en_i  = 1; if_nb.wr0_addr_i  = a; if_nb.wr0_data_i  = d;
    endtask

    task automatic set_wr1(input logic [2:0] a, input logic [18:0] d);
        if_byp.wr1_en_i = 1; if_byp.wr1_addr_i = a; if_byp.wr1_data_i = d;
        if_nb.wr1_en_i  = 1; if_nb.wr1_addr_i  = a; if_nb.wr1_data_i  = d;
    endtask

    task automatic set_rsv(input logic [2:0] a);
        if_byp.rsv_en_i = 1; if_byp.rsv_addr_i = a;
        if_nb.rsv_en_i  = 1; if_nb.rsv_addr_i  = a;
    endtask

    task automatic set_rd(input int p, input logic [2:0] a);
        if_byp.rd_addr_i[p] = a;
        if_nb.rd_addr_i[p]  = a;
    endtask

    task automatic test_reset();
        reset = 1;
        idle();
        set_wr0(3'd3, 19'h7_FFFF);
        if_w.wr0_en_i = 1; if_w.wr0_addr_i = 4'd15; if_w.wr0_data_i = 32'h1234_5678;
        step();
        step();
        reset = 0;
        idle();
        #1;
        checks++;
        if (if_byp.wr_collision_o !== 1'b0 || if_nb.wr_collision_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_collision: got %b/%b expected 0", if_byp.wr_collision_o, if_nb.wr_collision_o);
        end
        for (int r = 0; r < 8; r++) begin
            set_rd(0, 3'(r));
            set_rd(1, 3'(r));
            #1;
            checks++;
            if (if_byp.rd_data_o !== '0 || if_nb.rd_data_o !== '0) begin
                failures++;
                $display("FAIL reset_data r%0d: got %h/%h expected 0", r, if_byp.rd_data_o, if_nb.rd_data_o);
            end
            checks++;
            if (if_byp.rd_busy_o !== 2'b00 || if_nb.rd_busy_o !== 2'b00) begin
                failures++;
                $display("FAIL reset_busy r%0d: got %b/%b expected 00", r, if_byp.rd_busy_o, if_nb.rd_busy_o);
            end
        end
        for (int p = 0; p < 4; p++) if_w.rd_addr_i[p] = 4'd15;
        #1;
        checks++;
        if (if_w.rd_data_o !== '0 || if_w.rd_busy_o !== 4'b0000) begin
            failures++;
            $display("FAIL reset_wide: got %h busy %b expected 0", if_w.rd_data_o, if_w.rd_busy_o);
        end
    endtask

    task automatic test_bypass();
        set_wr0(3'd5, 19'h1_2345);
        set_rd(0, 3'd5);
        #1;
        checks++;
        if (if_byp.rd_data_o[0] !== 19'h1_2345) begin
            failures++;
            $display("FAIL bypass_same_cycle: got %h expected 12345", if_byp.rd_data_o[0]);
        end
        checks++;
        if (if_nb.rd_data_o[0] !== 19'h0) begin
            failures++;
            $display("FAIL nobypass_same_cycle: got %h expected 0", if_nb.rd_data_o[0]);
        end
        step();
        idle();
        #1;
        checks++;
        if (if_nb.rd_data_o[0] !== 19'h1_2345 || if_byp.rd_data_o[0] !== 19'h1_2345) begin
            failures++;
            $display("FAIL write_next_cycle: got %h/%h expected 12345", if_byp.rd_data_o[0], if_nb.rd_data_o[0]);
        end
    endtask

    task automatic test_collision();
        set_wr0(3'd2, 19'h0_00AA);
        set_wr1(3'd2, 19'h0_0055);
        set_rd(0, 3'd2);
        set_rd(1, 3'd2);
        #1;
        checks++;
        if (if_byp.rd_data_o[1] !== 19'h0_00AA || if_byp.wr_collision_o !== 1'b0) begin
            failures++;
            $display("FAIL collision_bypass: got %h coll %b expected 000aa coll 0", if_byp.rd_data_o[1], if_byp.wr_collision_o);
        end
        step();
        idle();
        #1;
        checks++;
        if (if_byp.rd_data_o[0] !== 19'h0_00AA || if_nb.rd_data_o[1] !== 19'h0_00AA) begin
            failures++;
            $display("FAIL collision_data: got %h/%h expected 000aa", if_byp.rd_data_o[0], if_nb.rd_data_o[1]);
        end
        checks++;
        if (if_byp.wr_collision_o !== 1'b1 || if_nb.wr_collision_o !== 1'b1) begin
            failures++;
            $display("FAIL collision_pulse: got %b/%b expected 1", if_byp.wr_collision_o, if_nb.wr_collision_o);
        end
        step();
        #1;
        checks++;
        if (if_byp.wr_collision_o !== 1'b0 || if_nb.wr_collision_o !== 1'b0) begin
            failures++;
            $display("FAIL collision_one_cycle: got %b/%b expected 0", if_byp.wr_collision_o, if_nb.wr_collision_o);
        end
    endtask

    task automatic test_zero_reg();
        set_wr0(3'd0, 19'h5_5555);
        set_wr1(3'd0, 19'h5_5555);
        set_rsv(3'd0);
        set_rd(0, 3'd0);
        set_rd(1, 3'd0);
        #1;
        checks++;
        if (if_byp.rd_data_o !== '0 || if_byp.rd_busy_o !== 2'b00) begin
            failures++;
            $display("FAIL zero_same_cycle: got %h busy %b expected 0", if_byp.rd_data_o, if_byp.rd_busy_o);
        end
        step();
        idle();
        #1;
        checks++;
        if (if_byp.rd_data_o !== '0 || if_nb.rd_data_o !== '0 ||
            if_byp.rd_busy_o !== 2'b00 || if_nb.rd_busy_o !== 2'b00) begin
            failures++;
            $display("FAIL zero_after: got %h/%h busy %b/%b expected 0", if_byp.rd_data_o, if_nb.rd_data_o, if_byp.rd_busy_o, if_nb.rd_busy_o);
        end
        checks++;
        if (if_byp.wr_collision_o !== 1'b0 || if_nb.wr_collision_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_collision: got %b/%b expected 0", if_byp.wr_collision_o, if_nb.wr_collision_o);
        end
    endtask

    task automatic test_scoreboard();
        set_rsv(3'd4);
        set_rd(0, 3'd4);
        #1;
        checks++;
        if (if_byp.rd_busy_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL rsv_same_cycle: got %b expected 0", if_byp.rd_busy_o[0]);
        end
        step();
        idle();
        #1;
        checks++;
        if (if_byp.rd_busy_o[0] !== 1'b1 || if_nb.rd_busy_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL rsv_next_cycle: got %b/%b expected 1", if_byp.rd_busy_o[0], if_nb.rd_busy_o[0]);
        end
        set_wr0(3'd4, 19'h0_0444);
        set_rsv(3'd4);
        #1;
        checks++;
        if (if_byp.rd_busy_o[0] !== 1'b1 || if_byp.rd_data_o[0] !== 19'h0_0444) begin
            failures++;
            $display("FAIL wr_rsv_same_cycle: got busy %b data %h expected 1 00444", if_byp.rd_busy_o[0], if_byp.rd_data_o[0]);
        end
        step();
        idle();
        #1;
        checks++;
        if (if_byp.rd_busy_o[0] !== 1'b1 || if_nb.rd_busy_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL wr_rsv_next_cycle: got %b/%b expected 1", if_byp.rd_busy_o[0], if_nb.rd_busy_o[0]);
        end
        set_wr1(3'd4, 19'h0_0777);
        #1;
        checks++;
        if (if_byp.rd_busy_o[0] !== 1'b0 || if_byp.rd_data_o[0] !== 19'h0_0777) begin
            failures++;
            $display("FAIL clear_bypass: got busy %b data %h expected 0 00777", if_byp.rd_busy_o[0], if_byp.rd_data_o[0]);
        end
        checks++;
        if (if_nb.rd_busy_o[0] !== 1'b1 || if_nb.rd_data_o[0] !== 19'h0_0444) begin
            failures++;
            $display("FAIL clear_nobypass: got busy %b data %h expected 1 00444", if_nb.rd_busy_o[0], if_nb.rd_data_o[0]);
        end
        step();
        idle();
        #1;
        checks++;
        if (if_byp.rd_busy_o[0] !== 1'b0 || if_nb.rd_busy_o[0] !== 1'b0 || if_nb.rd_data_o[0] !== 19'h0_0777) begin
            failures++;
            $display("FAIL clear_next_cycle: got busy %b/%b data %h expected 0/0 00777", if_byp.rd_busy_o[0], if_nb.rd_busy_o[0], if_nb.rd_data_o[0]);
        end
    endtask

    task automatic test_two_ports();
        set_wr0(3'd1, 19'h1_1111);
        set_wr1(3'd6, 19'h6_6666);
        set_rd(0, 3'd1);
        set_rd(1, 3'd6);
        #1;
        checks++;
        if (if_byp.rd_data_o[1] !== 19'h6_6666 || if_byp.rd_data_o[0] !== 19'h1_1111) begin
            failures++;
            $display("FAIL two_port_bypass: got %h expected 6666611111", if_byp.rd_data_o);
        end
        step();
        idle();
        #1;
        checks++;
        if (if_nb.rd_data_o[0] !== 19'h1_1111 || if_nb.rd_data_o[1] !== 19'h6_6666 ||
            if_nb.wr_collision_o !== 1'b0) begin
            failures++;
            $display("FAIL two_port_store: got %h coll %b expected 6666611111 coll 0", if_nb.rd_data_o, if_nb.wr_collision_o);
        end
    endtask

    task automatic test_back_to_back();
        set_wr0(3'd7, 19'h0_0001);
        set_rd(0, 3'd7);
        step();
        set_wr0(3'd7, 19'h0_0002);
        #1;
        checks++;
        if (if_byp.rd_data_o[0] !== 19'h0_0002 || if_nb.rd_data_o[0] !== 19'h0_0001) begin
            failures++;
            $display("FAIL b2b_mid: got %h/%h expected 00002/00001", if_byp.rd_data_o[0], if_nb.rd_data_o[0]);
        end
        step();
        idle();
        #1;
        checks++;
        if (if_byp.rd_data_o[0] !== 19'h0_0002 || if_nb.rd_data_o[0] !== 19'h0_0002) begin
            failures++;
            $display("FAIL b2b_end: got %h/%h expected 00002", if_byp.rd_data_o[0], if_nb.rd_data_o[0]);
        end
    endtask

    task automatic test_wide();
        if_w.wr0_en_i = 1; if_w.wr0_addr_i = 4'd15; if_w.wr0_data_i = 32'hDEAD_BEEF;
        for (int p = 0; p < 4; p++) if_w.rd_addr_i[p] = 4'd15;
        step();
        idle();
        #1;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (if_w.rd_data_o[p] !== 32'hDEAD_BEEF) begin
                failures++;
                $display("FAIL wide_port%0d: got %h expected deadbeef", p, if_w.rd_data_o[p]);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_wr0(3'd1, 19'h0_0ABC);
        set_rsv(3'd6);
        reset = 1;
        step();
        reset = 0;
        idle();
        set_rd(0, 3'd1);
        set_rd(1, 3'd6);
        #1;
        checks++;
        if (if_byp.rd_data_o[0] !== 19'h0 || if_nb.rd_data_o[1] !== 19'h0) begin
            failures++;
            $display("FAIL reset_mid_data: got %h/%h expected 0", if_byp.rd_data_o[0], if_nb.rd_data_o[1]);
        end
        checks++;
        if (if_byp.rd_busy_o !== 2'b00 || if_nb.rd_busy_o !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_busy: got %b/%b expected 00", if_byp.rd_busy_o, if_nb.rd_busy_o);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1;
        if_byp.rd_addr_i = '0; if_nb.rd_addr_i = '0; if_w.rd_addr_i = '0;
        if_byp.wr0_addr_i = '0; if_byp.wr0_data_i = '0; if_byp.wr1_addr_i = '0;
        if_byp.wr1_data_i = '0; if_byp.rsv_addr_i = '0;
        if_nb.wr0_addr_i = '0; if_nb.wr0_data_i = '0; if_nb.wr1_addr_i = '0;
        if_nb.wr1_data_i = '0; if_nb.rsv_addr_i = '0;
        if_w.wr0_addr_i = '0; if_w.wr0_data_i = '0; if_w.wr1_addr_i = '0;
        if_w.wr1_data_i = '0; if_w.rsv_addr_i = '0;
        idle();
        test_reset();
        test_bypass();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_two_ports();
        test_back_to_back();
        test_wide();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
